// File: rtl/mandelbrot_shader.sv
// Escape-time Mandelbrot colour source for the renderer pixel port; `MANDEL_GRAY_EN selects a grayscale palette.
// Latency n+3 cycles (LATCH, INIT, n+1 ITER, DONE); no backpressure, the renderer advances on pixel_done.
module mandelbrot_shader #(
    parameter int WIDTH    = 1280,
    parameter int HEIGHT   = 720,
    parameter int MAX_ITER = 64,
    parameter int FRAC     = 12,
    parameter int STEP     = 10,
    parameter int X_OFF    = 10240,
    parameter int Y_OFF    = 3600
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [$clog2(WIDTH)-1:0]  curr_x,
    input  logic [$clog2(HEIGHT)-1:0] curr_y,
    output logic                      pixel_done,
    output logic [7:0]                red_out,
    output logic [7:0]                green_out,
    output logic [7:0]                blue_out,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [24:0] ESC_LIMIT = 25'(4 << FRAC);
    localparam logic [7:0]  ITER_CAP  = 8'(MAX_ITER);

    typedef enum logic [1:0] {S_LATCH, S_INIT, S_ITER, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      x_q, x_d, ox_q, ox_d;
    logic [YW-1:0]      y_q, y_d, oy_q, oy_d;
    logic signed [23:0] cre_q, cre_d, cim_q, cim_d;
    logic signed [23:0] zr_q, zr_d, zi_q, zi_d;
    logic [7:0]         iter_q, iter_d;
    logic [7:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;

    // Full 48-bit product, keep Q11.FRAC window; dropping low bits floors toward -inf.
    function automatic logic signed [23:0] mul_q(input logic signed [23:0] a,
                                                 input logic signed [23:0] b);
        logic signed [47:0] p;
        p = $signed({{24{a[23]}}, a}) * $signed({{24{b[23]}}, b});
        return p[FRAC+23:FRAC];
    endfunction

    logic signed [23:0] rr, ii, ri;
    logic [24:0]        mag;
    logic               escape, capped;
    logic [7:0]         n4;

    assign rr     = mul_q(zr_q, zr_q);
    assign ii     = mul_q(zi_q, zi_q);
    assign ri     = mul_q(zr_q, zi_q);
    assign mag    = {1'b0, rr} + {1'b0, ii};
    assign escape = mag > ESC_LIMIT;
    assign capped = iter_q == ITER_CAP;
    assign n4     = {iter_q[5:0], 2'b00};
`ifndef MANDEL_GRAY_EN
    logic [7:0] n2;
    assign n2 = {iter_q[6:0], 1'b0};
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cre_d   = cre_q;
        cim_d   = cim_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        iter_d  = iter_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        case (state_q)
            S_LATCH: begin
                x_d     = curr_x;
                y_d     = curr_y;
                state_d = S_INIT;
            end
            S_INIT: begin
                cre_d   = $signed(24'(x_q) * 24'(STEP) - 24'(X_OFF));
                cim_d   = $signed(24'(y_q) * 24'(STEP) - 24'(Y_OFF));
                zr_d    = '0;
                zi_d    = '0;
                iter_d  = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (capped || escape) begin
                    state_d = S_DONE;
                    ox_d    = x_q;
                    oy_d    = y_q;
                    // Cap is tested first so an interior point that also escapes stays black.
                    if (capped) begin
                        red_d   = '0;
                        green_d = '0;
                        blue_d  = '0;
                    end else begin
`ifdef MANDEL_GRAY_EN
                        red_d   = n4;
                        green_d = n4;
                        blue_d  = n4;
`else
                        red_d   = n4;
                        green_d = n2;
                        blue_d  = ~n4;
`endif
                    end
                end else begin
                    zr_d   = rr - ii + cre_q;
                    zi_d   = (ri <<< 1) + cim_q;
                    iter_d = iter_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_LATCH;
            default: state_d = S_LATCH;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_LATCH;
            x_q     <= '0;
            y_q     <= '0;
            cre_q   <= '0;
            cim_q   <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            iter_q  <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cre_q   <= cre_d;
            cim_q   <= cim_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            iter_q  <= iter_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    // Gated by reset so a job caught in DONE by reset never strobes.
    assign pixel_done = (state_q == S_DONE) && !rst_in;
    assign red_out    = red_q;
    assign green_out  = green_q;
    assign blue_out   = blue_q;
    assign out_x      = ox_q;
    assign out_y      = oy_q;
endmodule

// File: tb/tb_mandelbrot_shader.sv
// Bench for mandelbrot_shader: table vectors, renderer counter run, random pixels vs. an arithmetic model, reset corners.
module tb_mandelbrot_shader;
    localparam int MI = 64;

    logic        clk = 1'b0;
    logic        rst_in, rst8;
    logic [10:0] curr_x, curr_x8, out_x, out_x8;
    logic [9:0]  curr_y, curr_y8, out_y, out_y8;
    logic        pixel_done, pixel_done8;
    logic [7:0]  red_out, green_out, blue_out, red8, green8, blue8;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int dbl_cnt = 0;
    bit prev_done = 1'b0;

    always #5 clk = ~clk;

    mandelbrot_shader dut (
        .clk_in(clk), .rst_in(rst_in), .curr_x(curr_x), .curr_y(curr_y),
        .pixel_done(pixel_done), .red_out(red_out), .green_out(green_out),
        .blue_out(blue_out), .out_x(out_x), .out_y(out_y)
    );

    mandelbrot_shader #(.MAX_ITER(8)) dut8 (
        .clk_in(clk), .rst_in(rst8), .curr_x(curr_x8), .curr_y(curr_y8),
        .pixel_done(pixel_done8), .red_out(red8), .green_out(green8),
        .blue_out(blue8), .out_x(out_x8), .out_y(out_y8)
    );

    always @(negedge clk) begin
        if (pixel_done) strobes++;
        if (pixel_done && prev_done) dbl_cnt++;
        prev_done = pixel_done;
    end

    // Reference: plain escape-time iteration on integers scaled by 2^12.
    function automatic longint w24(input longint v);
        longint m;
        m = v & 64'hFFFFFF;
        return (m >= 64'h800000) ? m - 64'h1000000 : m;
    endfunction

    function automatic int ref_n(input int x, input int y, input int maxit);
        longint cr, ci, zr, zi, rr, ii, t;
        int n;
        cr = longint'(x) * 10 - 10240;
        ci = longint'(y) * 10 - 3600;
        zr = 0; zi = 0; n = 0;
        while (n < maxit) begin
            rr = (zr * zr) >>> 12;
            ii = (zi * zi) >>> 12;
            if ((rr & 64'hFFFFFF) + (ii & 64'hFFFFFF) > 16384) break;
            t  = (zr * zi) >>> 12;
            zr = w24(w24(rr) - w24(ii) + cr);
            zi = w24(2 * w24(t) + ci);
            n++;
        end
        return n;
    endfunction

    function automatic logic [23:0] ref_rgb(input int n, input int maxit);
        logic [7:0] r, g, b;
        if (n == maxit) return 24'h0;
        r = 8'((n * 4) % 256);
        g = 8'((n * 2) % 256);
        b = 8'(255 - int'(r));
`ifdef MANDEL_GRAY_EN
        return {r, r, r};
`else
        return {r, g, b};
`endif
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Counts cycles from the next LATCH cycle to the strobe; scribbles on the coordinate mid-job.
    task automatic wait_strobe(output int cyc);
        logic [23:0] h_rgb;
        bit hold_bad;
        h_rgb = {red_out, green_out, blue_out};
        hold_bad = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (pixel_done) break;
            if ({red_out, green_out, blue_out} !== h_rgb) hold_bad = 1'b1;
            if (cyc == 2) begin
                curr_x = 11'($urandom);
                curr_y = 10'($urandom);
            end
            cyc++;
            if (cyc > 400) begin
                checks++;
                errors++;
                $display("FAIL strobe_timeout: got no strobe in %0d cycles, expected one", cyc);
                cyc = -1;
                return;
            end
        end
        chk("colour_hold", longint'(hold_bad), 0);
    endtask

    task automatic wait_strobe8(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (pixel_done8) break;
            cyc++;
            if (cyc > 400) begin
                checks++;
                errors++;
                $display("FAIL strobe8_timeout: got no strobe in %0d cycles, expected one", cyc);
                cyc = -1;
                return;
            end
        end
    endtask

    task automatic run_job(input string tag, input int x, input int y,
                           input int exp_lat, input logic [23:0] exp_rgb);
        int lat;
        curr_x = 11'(x);
        curr_y = 10'(y);
        wait_strobe(lat);
        if (lat < 0) return;
        chk({tag, "_latency"}, longint'(lat), longint'(exp_lat));
        chk({tag, "_rgb"}, longint'({red_out, green_out, blue_out}), longint'(exp_rgb));
        chk({tag, "_out_x"}, longint'(out_x), longint'(x));
        chk({tag, "_out_y"}, longint'(out_y), longint'(y));
    endtask

    typedef struct {
        int          x;
        int          y;
        int          lat;
        logic [23:0] rgb;
    } vec_t;

    vec_t vec [6];

    function automatic vec_t model_row(input int x, input int y);
        vec_t v;
        int n;
        n = ref_n(x, y, MI);
        v.x = x; v.y = y; v.lat = n + 3; v.rgb = ref_rgb(n, MI);
        return v;
    endfunction

    initial begin
        int lat, s0, early, x, y;
`ifdef MANDEL_GRAY_EN
        vec[0] = '{0, 0, 4, 24'h040404};
`else
        vec[0] = '{0, 0, 4, 24'h0402FB};
`endif
        vec[1] = '{1024, 360, 67, 24'h000000};
        vec[2] = model_row(700, 400);
        vec[3] = model_row(900, 300);
        vec[4] = model_row(500, 100);
        vec[5] = model_row(1279, 719);

        rst_in = 1'b1; rst8 = 1'b1;
        curr_x = '0; curr_y = '0; curr_x8 = '0; curr_y8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_done", longint'(pixel_done), 0);
        chk("reset_rgb", longint'({red_out, green_out, blue_out}), 0);
        chk("reset_out_xy", longint'({out_x, out_y}), 0);
        @(posedge clk);
        #1 rst_in = 1'b0;

        for (int i = 0; i < 6; i++)
            run_job($sformatf("vec%0d", i), vec[i].x, vec[i].y, vec[i].lat, vec[i].rgb);

        // Renderer counter: advance x on each strobe, 20 pixels.
        s0 = strobes;
        for (int i = 0; i < 20; i++)
            run_job($sformatf("row%0d", i), i, 360, ref_n(i, 360, MI) + 3, ref_rgb(ref_n(i, 360, MI), MI));
        chk("row_strobe_count", longint'(strobes - s0), 20);

        for (int i = 0; i < 24; i++) begin
            x = int'($urandom_range(560, 1150));
            y = int'($urandom_range(160, 560));
            run_job($sformatf("rnd%0d", i), x, y, ref_n(x, y, MI) + 3, ref_rgb(ref_n(x, y, MI), MI));
        end
        chk("double_strobe", longint'(dbl_cnt), 0);

        // Reset landing in the DONE cycle suppresses the strobe.
        curr_x = '0; curr_y = '0;
        early = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (pixel_done) early++;
        end
        chk("done_rst_early", longint'(early), 0);
        @(posedge clk);
        #1 rst_in = 1'b1;
        @(negedge clk);
        chk("done_rst_strobe", longint'(pixel_done), 0);
        chk("done_rst_loaded", longint'({red_out, green_out, blue_out}), longint'(vec[0].rgb));
        @(negedge clk);
        chk("done_rst_clear", longint'({red_out, green_out, blue_out}), 0);
        @(posedge clk);
        #1 rst_in = 1'b0;
        run_job("restart", 0, 0, 4, vec[0].rgb);

        // One-cycle reset pulse in the middle of an interior-point job.
        curr_x = 11'd1024; curr_y = 10'd360;
        early = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (pixel_done) early++;
        end
        rst_in = 1'b1;
        curr_x = '0; curr_y = '0;
        @(posedge clk);
        #1;
        chk("abort_strobe", longint'(early + int'(pixel_done)), 0);
        chk("abort_rgb", longint'({red_out, green_out, blue_out}), 0);
        chk("abort_out_xy", longint'({out_x, out_y}), 0);
        rst_in = 1'b0;
        wait_strobe(lat);
        chk("abort_next_latency", longint'(lat), 4);
        chk("abort_next_rgb", longint'({red_out, green_out, blue_out}), longint'(vec[0].rgb));

        // Instance with an iteration cap of 8.
        curr_x8 = 11'd1024; curr_y8 = 10'd360;
        @(posedge clk);
        #1 rst8 = 1'b0;
        wait_strobe8(lat);
        chk("cap8_latency", longint'(lat), 11);
        chk("cap8_rgb", longint'({red8, green8, blue8}), 0);
        chk("cap8_out_xy", longint'({out_x8, out_y8}), longint'({11'd1024, 10'd360}));
        curr_x8 = '0; curr_y8 = '0;
        wait_strobe8(lat);
        chk("cap8_origin_latency", longint'(lat), 4);
        chk("cap8_origin_rgb", longint'({red8, green8, blue8}), longint'(ref_rgb(1, 8)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
